// File: rtl/transform_scheduler.sv
// Round-robin scheduler sharing one 2-point butterfly; a tag FIFO routes each result pair home.
// Latency: zero, samples and results pass through combinationally; only grant/tag/beat state is held.
// Backpressure: grants stall while the tag FIFO is full; TRANSFORM_SCHEDULER_STATS_EN adds stat_pairs.

module transform_scheduler_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

module transform_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         s_valid,
  output logic [NUM_REQ-1:0]         s_ready,
  input  logic [NUM_REQ*2*WIDTH-1:0] s_data,
  output logic                       t_s_valid,
  input  logic                       t_s_ready,
  output logic [2*WIDTH-1:0]         t_s_data,
  input  logic                       t_m_valid,
  output logic                       t_m_ready,
  input  logic [2*WIDTH+1:0]         t_m_data,
  output logic [NUM_REQ-1:0]         m_valid,
  input  logic [NUM_REQ-1:0]         m_ready,
  output logic [2*WIDTH+1:0]         m_data,
  output logic                       m_last
`ifdef TRANSFORM_SCHEDULER_STATS_EN
  ,
  output logic [15:0]                stat_pairs
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_last;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  logic [GW-1:0] head;
  logic          win_vld;
  logic          grant_ld;
  logic          s_hs;
  logic          m_hs;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          beat;

  // Search starts one past the previous winner; reset leaves rr_last at NUM_REQ-1 so requester 0 leads.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(rr_last) + k) % NUM_REQ);
      if (!win_vld && s_valid[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_ld  = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld && !full) begin
          state_nxt = FIRST;
          grant_ld  = 1'b1;
        end
      end
      FIRST: begin
        if (s_hs) state_nxt = SECOND;
      end
      SECOND: begin
        if (s_hs) begin
          state_nxt = IDLE;
          push      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= '0;
      rr_last <= GW'(NUM_REQ-1);
      beat    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ld) begin
        grant   <= win;
        rr_last <= win;
      end
      if (m_hs) beat <= ~beat;
    end
  end

  always_comb begin
    t_s_valid = 1'b0;
    s_ready   = '0;
    if (state != IDLE) begin
      t_s_valid      = s_valid[grant];
      s_ready[grant] = t_s_ready;
    end
  end

  assign t_s_data = s_data[int'(grant)*SW +: SW];
  assign s_hs     = t_s_valid & t_s_ready;

  always_comb begin
    m_valid   = '0;
    t_m_ready = 1'b0;
    if (!empty) begin
      m_valid[head] = t_m_valid;
      t_m_ready     = m_ready[head];
    end
  end

  assign m_data = t_m_data;
  assign m_last = beat;
  assign m_hs   = t_m_valid & t_m_ready;
  assign pop    = m_hs & beat;

  transform_scheduler_fifo #(.W(GW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (grant),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

`ifdef TRANSFORM_SCHEDULER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  stat_pairs <= '0;
    else if (pop)  stat_pairs <= stat_pairs + 16'd1;
  end
`endif
endmodule

// File: tb/tb_transform_scheduler.sv
// Randomized bench for transform_scheduler: a queue-based model of requesters, butterfly and tag order.
`timescale 1ns/1ps
module tb_transform_scheduler;
  localparam int W = 16, N = 4, D = 4;
  localparam int SW = 2*W, RW = 2*W+2, MAXS = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] s_valid, s_ready, m_valid, m_ready;
  logic [N*SW-1:0] s_data;
  logic t_s_valid, t_s_ready, t_m_valid, t_m_ready, m_last;
  logic [SW-1:0] t_s_data;
  logic [RW-1:0] t_m_data, m_data;
`ifdef TRANSFORM_SCHEDULER_STATS_EN
  logic [15:0] stat_pairs;
`endif

  transform_scheduler #(.WIDTH(W), .NUM_REQ(N), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .t_s_valid(t_s_valid), .t_s_ready(t_s_ready), .t_s_data(t_s_data),
    .t_m_valid(t_m_valid), .t_m_ready(t_m_ready), .t_m_data(t_m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef TRANSFORM_SCHEDULER_STATS_EN
    , .stat_pairs(stat_pairs)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  logic [SW-1:0] src [N][MAXS];
  logic [RW-1:0] rx_dat [N][MAXS];
  logic          rx_last [N][MAXS];
  int src_wr[N], src_rd[N], rcv[N], hold_cnt[N];
  int owner, nsamp, last_owner, pops, obs_acc;
  logic beat_m;
  int tagq[$];
  int grant_log[$];
  logic [RW-1:0] bf_out[$];
  logic [SW-1:0] bf_a;
  logic bf_have;
  logic [N-1:0] last_sr;
  logic last_tsv;
  int gap_pct, ts_pct, tm_pct, mr_pct, hold_req, hold_len;

  function automatic logic [RW-1:0] bfly(input logic [SW-1:0] a, input logic [SW-1:0] b, input bit diff);
    logic signed [W:0] ar, ai, br, bi, rr, ri;
    ar = {a[W-1], a[W-1:0]};
    ai = {a[SW-1], a[SW-1:W]};
    br = {b[W-1], b[W-1:0]};
    bi = {b[SW-1], b[SW-1:W]};
    rr = diff ? ar - br : ar + br;
    ri = diff ? ai - bi : ai + bi;
    return {ri, rr};
  endfunction

  function automatic bit busy();
    bit b;
    b = (owner >= 0) || (tagq.size() > 0) || (bf_out.size() > 0);
    for (int i = 0; i < N; i++) if (src_rd[i] < src_wr[i]) b = 1'b1;
    return b;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; rcv[i] = 0; hold_cnt[i] = 0;
    end
    owner = -1; nsamp = 0; last_owner = N-1; beat_m = 1'b0; pops = 0; obs_acc = 0;
    tagq.delete(); bf_out.delete(); grant_log.delete(); bf_have = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_valid = '0; s_data = '0; t_s_ready = 1'b0; t_m_valid = 1'b0; t_m_data = '0; m_ready = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_knobs(input int gap, input int ts, input int tm, input int mr);
    gap_pct = gap; ts_pct = ts; tm_pct = tm; mr_pct = mr;
  endtask

  task automatic add_sample(input int i, input logic [SW-1:0] dat);
    if (src_wr[i] < MAXS) begin
      src[i][src_wr[i]] = dat;
      src_wr[i]++;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance the model at the edge.
  task automatic step();
    logic [N-1:0] exp_sr, exp_mv;
    logic exp_tsv, exp_tmr, s_hs, m_hs, ml, found;
    logic [RW-1:0] md;
    logic [SW-1:0] tsd;
    int h, k, c, pre_owner, pre_tags;
    bit has;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      has = src_rd[i] < src_wr[i];
      if (hold_cnt[i] > 0) begin
        hold_cnt[i]--;
        s_valid[i] = 1'b0;
      end else begin
        s_valid[i] = has && ($urandom_range(99) >= gap_pct);
      end
      s_data[i*SW +: SW] = has ? src[i][src_rd[i]] : $urandom;
      m_ready[i] = $urandom_range(99) < mr_pct;
    end
    t_s_ready = $urandom_range(99) < ts_pct;
    t_m_valid = (bf_out.size() > 0) && ($urandom_range(99) < tm_pct);
    t_m_data  = (bf_out.size() > 0) ? bf_out[0] : RW'({$urandom, $urandom});
    #1;
    exp_sr = '0; exp_tsv = 1'b0; exp_mv = '0; exp_tmr = 1'b0;
    if (owner >= 0) begin
      exp_tsv = s_valid[owner];
      exp_sr[owner] = t_s_ready;
    end
    if (tagq.size() > 0) begin
      exp_mv[tagq[0]] = t_m_valid;
      exp_tmr = m_ready[tagq[0]];
    end
    checks++;
    if ({s_ready, t_s_valid, m_valid, t_m_ready, m_last} !== {exp_sr, exp_tsv, exp_mv, exp_tmr, beat_m})
      $display("FAIL handshake t=%0t got sr=%b tsv=%b mv=%b tmr=%b last=%b want sr=%b tsv=%b mv=%b tmr=%b last=%b",
               $time, s_ready, t_s_valid, m_valid, t_m_ready, m_last, exp_sr, exp_tsv, exp_mv, exp_tmr, beat_m);
    else passes++;
    if (exp_tsv) begin
      checks++;
      if (t_s_data !== src[owner][src_rd[owner]])
        $display("FAIL t_s_data t=%0t got %h want %h", $time, t_s_data, src[owner][src_rd[owner]]);
      else passes++;
    end
    if (|(s_ready & s_valid)) obs_acc++;
    last_sr = s_ready; last_tsv = t_s_valid;
    s_hs = exp_tsv && t_s_ready;
    m_hs = (tagq.size() > 0) && t_m_valid && m_ready[tagq[0]];
    md = m_data; ml = m_last; tsd = t_s_data;
    pre_owner = owner; pre_tags = tagq.size();
    @(posedge clk);
    if (m_hs) begin
      h = tagq[0];
      k = rcv[h];
      checks++;
      if (md !== bfly(src[h][2*(k/2)], src[h][2*(k/2)+1], (k%2) == 1))
        $display("FAIL m_data req%0d result%0d got %h want %h", h, k, md,
                 bfly(src[h][2*(k/2)], src[h][2*(k/2)+1], (k%2) == 1));
      else passes++;
      rx_dat[h][k] = md; rx_last[h][k] = ml; rcv[h]++;
      void'(bf_out.pop_front());
      if (beat_m) begin
        void'(tagq.pop_front());
        pops++;
      end
      beat_m = ~beat_m;
    end
    if (s_hs) begin
      if (bf_have) begin
        bf_out.push_back(bfly(bf_a, tsd, 1'b0));
        bf_out.push_back(bfly(bf_a, tsd, 1'b1));
        bf_have = 1'b0;
      end else begin
        bf_a = tsd;
        bf_have = 1'b1;
      end
      src_rd[owner]++;
      if (nsamp == 0) begin
        nsamp = 1;
        if (hold_req == owner) hold_cnt[owner] = hold_len;
      end else begin
        tagq.push_back(owner);
        owner = -1;
        nsamp = 0;
      end
    end
    if (pre_owner < 0 && (|s_valid) && pre_tags < D) begin
      found = 1'b0;
      for (int j = 1; j <= N; j++) begin
        c = (last_owner + j) % N;
        if (!found && s_valid[c]) begin
          owner = c;
          found = 1'b1;
        end
      end
      last_owner = owner; nsamp = 0;
      grant_log.push_back(owner);
    end
  endtask

  task automatic run_drain(input int budget, input string name);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy()) $display("FAIL %s drain timeout got %0d cycles want completion", name, n);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_valid = '1; s_data = '1; t_s_ready = 1'b1; t_m_valid = 1'b1; t_m_data = '1; m_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== '0) $display("FAIL reset_s_ready got %b want 0", s_ready); else passes++;
    checks++; if (t_s_valid !== 1'b0) $display("FAIL reset_t_s_valid got %b want 0", t_s_valid); else passes++;
    checks++; if (m_valid !== '0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passes++;
    checks++; if (t_m_ready !== 1'b0) $display("FAIL reset_t_m_ready got %b want 0", t_m_ready); else passes++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else passes++;
    do_reset();
    set_knobs(0, 100, 100, 100);
    repeat (3) step();
  endtask

  task automatic test_single();
    logic [RW-1:0] want_sum, want_dif;
    want_sum = {17'd6, 17'd4};
    want_dif = {17'h1fffe, 17'h1fffe};
    do_reset();
    set_knobs(0, 100, 100, 100);
    add_sample(1, {16'd2, 16'd1});
    add_sample(1, {16'd4, 16'd3});
    run_drain(50, "single");
    checks++; if (rcv[1] !== 2) $display("FAIL single_count got %0d want 2", rcv[1]); else passes++;
    checks++;
    if ({rx_dat[1][0], rx_last[1][0]} !== {want_sum, 1'b0})
      $display("FAIL single_sum got %h/%b want %h/0", rx_dat[1][0], rx_last[1][0], want_sum);
    else passes++;
    checks++;
    if ({rx_dat[1][1], rx_last[1][1]} !== {want_dif, 1'b1})
      $display("FAIL single_diff got %h/%b want %h/1", rx_dat[1][1], rx_last[1][1], want_dif);
    else passes++;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_knobs(0, 100, 100, 100);
    for (int i = 0; i < N; i++) repeat (4) add_sample(i, $urandom);
    run_drain(200, "round_robin");
    checks++;
    if (grant_log.size() !== 2*N) $display("FAIL rr_grants got %0d want %0d", grant_log.size(), 2*N);
    else passes++;
    for (int g = 0; g < 5 && g < grant_log.size(); g++) begin
      checks++;
      if (grant_log[g] !== g % N) $display("FAIL rr_order idx%0d got %0d want %0d", g, grant_log[g], g % N);
      else passes++;
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_knobs(0, 100, 100, 100);
    hold_req = 2; hold_len = 5;
    for (int i = 0; i < N; i++) repeat (2) add_sample(i, $urandom);
    run_drain(200, "hold");
    hold_req = -1;
    checks++;
    if (rcv[2] !== 2) $display("FAIL hold_results got %0d want 2", rcv[2]); else passes++;
    for (int g = 0; g < N && g < grant_log.size(); g++) begin
      checks++;
      if (grant_log[g] !== g) $display("FAIL hold_order idx%0d got %0d want %0d", g, grant_log[g], g);
      else passes++;
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_knobs(0, 100, 100, 0);
    for (int i = 0; i < N; i++) repeat (6) add_sample(i, $urandom);
    repeat (40) step();
    checks++;
    if (obs_acc !== 2*D) $display("FAIL full_accepted got %0d want %0d", obs_acc, 2*D); else passes++;
    checks++;
    if ({last_sr, last_tsv} !== '0) $display("FAIL full_stalled got sr=%b tsv=%b want 0", last_sr, last_tsv);
    else passes++;
    mr_pct = 100;
    run_drain(400, "fifo_full");
    checks++;
    if (obs_acc !== 6*N) $display("FAIL full_total got %0d want %0d", obs_acc, 6*N); else passes++;
  endtask

  task automatic test_reset_mid_pair();
    int n;
    do_reset();
    set_knobs(0, 100, 100, 0);
    for (int i = 0; i < N; i++) repeat (6) add_sample(i, $urandom);
    n = 0;
    while (!(owner >= 0 && nsamp == 1 && tagq.size() == 2) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) $display("FAIL midpair_reach got timeout want second-with-2-tags"); else passes++;
    #2;
    s_valid = '1; t_s_ready = 1'b1; t_m_valid = 1'b1; m_ready = '1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, t_s_valid, m_valid, t_m_ready} !== '0)
      $display("FAIL midpair_outputs got sr=%b tsv=%b mv=%b tmr=%b want 0", s_ready, t_s_valid, m_valid, t_m_ready);
    else passes++;
    do_reset();
    set_knobs(0, 100, 100, 100);
    for (int i = 0; i < N; i++) repeat (2) add_sample(i, $urandom);
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 0)
      $display("FAIL midpair_first_grant got %0d want 0", grant_log.size() ? grant_log[0] : -1);
    else passes++;
    run_drain(200, "midpair");
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_knobs($urandom_range(40), 40 + $urandom_range(60), 40 + $urandom_range(60), 30 + $urandom_range(70));
      for (int i = 0; i < N; i++) repeat (2 * $urandom_range(1, 6)) add_sample(i, $urandom);
      run_drain(3000, "random");
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rcv[i] !== src_wr[i]) $display("FAIL random_count req%0d got %0d want %0d", i, rcv[i], src_wr[i]);
      else passes++;
    end
`ifdef TRANSFORM_SCHEDULER_STATS_EN
    checks++;
    if (stat_pairs !== 16'(pops)) $display("FAIL stat_pairs got %0d want %0d", stat_pairs, pops);
    else passes++;
`endif
  endtask

  initial begin
    hold_req = -1; hold_len = 0;
    clear_model();
    set_knobs(0, 100, 100, 100);
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_fifo_full();
    test_reset_mid_pair();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
